mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter for the pipelined core's unified instruction/data RAM. It shares one synchronous single-port RAM (1-cycle read latency) between the fetch stage (I port) and the memory stage (D port). It grants at most one access per cycle and routes the returning read data to the port that issued it. It sits between the pipeline and the RAM inside `top`; a fetch that is not granted stalls the front end.

## Interface
- `ADDR_W`, 32: byte-address width of both request ports.
- `DEPTH_LOG2`, 10: log2 of RAM depth in 32-bit words.
- `MAX_DSTREAK`, 4: consecutive contested D grants before I is forced through (≥1; used only with the fairness feature).

Ports:
- `sys_clk`  in  1: clock; all state on rising edge.
- `sys_rst`  in  1: asynchronous, active-high reset.
- `i_req`  in  1: fetch request; held until `i_gnt`.
- `i_addr`  in  ADDR_W: fetch byte address.
- `i_kill`  in  1: pipeline redirect; squashes the in-flight fetch return.
- `i_gnt`  out  1: fetch accepted this cycle (combinational).
- `i_rvalid`  out  1: fetch data valid.
- `i_rdata`  out  32: fetch data.
- `d_req`  in  1: data request; held until `d_gnt`.
- `d_we`  in  1: 1 = write, 0 = read.
- `d_wstrb`  in  4: byte enables for writes.
- `d_addr`  in  ADDR_W: data byte address.
- `d_wdata`  in  32: write data.
- `d_gnt`  out  1: data accepted this cycle (combinational).
- `d_rvalid`  out  1: load data valid.
- `d_rdata`  out  32: load data.
- `ram_en`  out  1: RAM access enable.
- `ram_we`  out  4: per-byte write enable.
- `ram_addr`  out  DEPTH_LOG2: word index.
- `ram_wdata`  out  32: write data.
- `ram_rdata`  in  32: RAM read data, valid 1 cycle after `ram_en`.

## Operation
- Grant rule (combinational):
  - Only one requester: it is granted.
  - Both requesting: D wins. Exception: with fairness compiled in and the streak counter equal to `MAX_DSTREAK`, I wins.
  - `i_gnt` and `d_gnt` are never both high.
- RAM drive:
  - `ram_en = i_gnt | d_gnt`.
  - `ram_addr = granted_addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored (wrap) and `addr[1:0]` is ignored.
  - `ram_we = d_wstrb` when D is granted with `d_we`; otherwise 0.
- Owner register `rd_owner_q` ∈ {NONE, IFETCH, DLOAD}:
  - Loaded each cycle: IFETCH if `i_gnt`; DLOAD if `d_gnt & ~d_we`; else NONE.
  - Writes produce no return.
- Return path:
  - `i_rdata = d_rdata = ram_rdata` (unqualified).
  - `i_rvalid = (rd_owner_q==IFETCH) & ~kill_q`.
  - `d_rvalid = (rd_owner_q==DLOAD)`.
- Kill:
  - `kill_q` registers `i_kill`.
  - If `i_kill` is high in the cycle an I grant occurs, that grant's `i_rvalid` is suppressed the next cycle.
  - If `i_kill` is high in the return cycle itself, `i_rvalid` for that cycle is also forced low.
  - Kill never affects the D port.

## Timing
- Reset values: `rd_owner_q`=NONE, `kill_q`=0, streak=0. Hence `i_rvalid`=`d_rvalid`=0. `ram_en`/`gnt` follow the request inputs combinationally, so they are 0 when there are no requests.
- Latency: grant in cycle N gives rvalid in cycle N+1. Throughput is one access per cycle, back-to-back, with no bubbles.
- Handshake: the requester must hold req/addr/data stable until gnt. Dropping req before gnt is legal; nothing is issued.
- Reset asserted mid-access: the pending return is lost and no rvalid follows reset release.
- Fairness counter (`streak`, width clog2(MAX_DSTREAK+1)):
  - Increments when `d_gnt & i_req`.
  - Clears when `i_gnt` or `~i_req`.
  - Saturates at `MAX_DSTREAK`.

## Configuration
- `MEM_ARB_FAIR_EN` defined: streak counter present. Under continuous contention, I is granted once after every `MAX_DSTREAK` D grants.
- Undefined: strict D-over-I priority. The counter and `MAX_DSTREAK` are unused, and I can starve while D is continuously requested.

## Structure
- Package `mem_arb_pkg`:
  - Owner enum (NONE/IFETCH/DLOAD).
  - `RAM_RD_LAT=1`.
  - Word-index helper function.
- Sub-module `mem_arb_starve_ctr`: streak counter plus force-I output. It is instantiated only under `MEM_ARB_FAIR_EN`.

## Test plan
- I-only: `i_req`=1 at 0x0,0x4,0x8 → `i_gnt` each cycle, `ram_addr` 0,1,2; `i_rvalid` one cycle later with matching RAM words.
- Contention without fairness: both req, `d_we`=0, `d_addr`=0x100 → `d_gnt`=1, `i_gnt`=0; `d_rvalid` next cycle with `ram_rdata` from word 0x40; I proceeds once `d_req` drops.
- Store: `d_we`=1, `d_wstrb`=4'b0011, `d_addr`=0x10, `d_wdata`=0xDEADBEEF → `ram_we`=0011, `ram_addr`=4, no `d_rvalid` next cycle.
- Fairness (`MEM_ARB_FAIR_EN`, `MAX_DSTREAK`=4), both requesting continuously → grant sequence D,D,D,D,I,D,D,D,D,I.
- Kill: I granted at 0x20 with `i_kill`=1 the same cycle → `i_rvalid`=0 next cycle; a following grant without kill returns normally.
- Reset: assert `sys_rst` in the cycle after a D load grant → `d_rvalid` stays 0 and the streak clears; after release, the first grant returns after 1 cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified I/D RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    IFETCH = 2'd1,
    DLOAD  = 2'd2
  } owner_e;

  localparam int RAM_RD_LAT = 1;
  localparam int MAX_ADDR_W = 64;

  // Byte address to 32-bit word index; callers truncate to the RAM depth.
  function automatic logic [MAX_ADDR_W-1:0] word_idx(input logic [MAX_ADDR_W-1:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and RAM-side signals around mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 10
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_kill;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [31:0]           i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [3:0]            d_wstrb;
  logic [ADDR_W-1:0]     d_addr;
  logic [31:0]           d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;

  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, i_kill, d_req, d_we, d_wstrb, d_addr, d_wdata, ram_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  // Pipeline + RAM side.
  modport master (
    output i_req, i_addr, i_kill, d_req, d_we, d_wstrb, d_addr, d_wdata, ram_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive contested D grants; raises force_i_o once the streak
// reaches MAX_DSTREAK so the waiting fetch gets one slot.
module mem_arb_starve_ctr #(
  parameter int MAX_DSTREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req_i,
  input  logic i_gnt_i,
  input  logic d_gnt_i,
  output logic force_i_o
);
  localparam int CW = $clog2(MAX_DSTREAK + 1);
  localparam logic [CW-1:0] STREAK_MAX = CW'(MAX_DSTREAK);

  logic [CW-1:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (i_gnt_i || !i_req_i)
      streak_d = '0;
    else if (d_gnt_i && streak_q != STREAK_MAX)
      streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end

  assign force_i_o = (streak_q == STREAK_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: one access per cycle, D over I, read data steered
// to the issuing port. Define MEM_ARB_FAIR_EN to bound fetch starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int MAX_DSTREAK = 4
) (
  input logic          sys_clk,
  input logic          sys_rst,
  mem_arbiter_if.slave bus
);
  logic              i_gnt, d_gnt, force_i;
  logic [ADDR_W-1:0] gaddr;
  owner_e            rd_owner_q, rd_owner_d;
  logic              kill_q;

`ifdef MEM_ARB_FAIR_EN
  mem_arb_starve_ctr #(.MAX_DSTREAK(MAX_DSTREAK)) u_starve (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .i_req_i  (bus.i_req),
    .i_gnt_i  (i_gnt),
    .d_gnt_i  (d_gnt),
    .force_i_o(force_i)
  );
`else
  localparam int unused_max_dstreak = MAX_DSTREAK;
  assign force_i = 1'b0;
`endif

  assign d_gnt = bus.d_req & ~(bus.i_req & force_i);
  assign i_gnt = bus.i_req & ~d_gnt;
  assign gaddr = d_gnt ? bus.d_addr : bus.i_addr;

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.ram_en    = i_gnt | d_gnt;
  assign bus.ram_addr  = DEPTH_LOG2'(word_idx(MAX_ADDR_W'(gaddr)));
  assign bus.ram_we    = (d_gnt && bus.d_we) ? bus.d_wstrb : 4'b0000;
  assign bus.ram_wdata = bus.d_wdata;

  // Stores return nothing, so only fetches and loads claim the next cycle's data.
  always_comb begin
    rd_owner_d = NONE;
    if (i_gnt)                    rd_owner_d = IFETCH;
    else if (d_gnt && !bus.d_we)  rd_owner_d = DLOAD;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_owner_q <= NONE;
      kill_q     <= 1'b0;
    end else begin
      rd_owner_q <= rd_owner_d;
      kill_q     <= bus.i_kill;
    end
  end

  // A redirect either at issue or during the return squashes the fetch data.
  assign bus.i_rvalid = (rd_owner_q == IFETCH) && !kill_q && !bus.i_kill;
  assign bus.d_rvalid = (rd_owner_q == DLOAD);
  assign bus.i_rdata  = bus.ram_rdata;
  assign bus.d_rdata  = bus.ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int ADDR_W = 32, DEPTH_LOG2 = 10, MAXD = 4, WORDS = 1 << DEPTH_LOG2;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   checks = 0, failures = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .MAX_DSTREAK(MAXD)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // RAM stimulus: synchronous, 1-cycle read latency, byte writes.
  logic [31:0] mem [0:WORDS-1];
  bit          ram_init = 1'b0;
  always @(posedge sys_clk) begin
    if (!ram_init) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
    end
  end

  // Reference model: who gets the slot, what comes back next cycle, memory image.
  int          m_owner = 0;      // 0 none, 1 fetch, 2 load
  bit          m_killq = 1'b0;
  int          m_streak = 0;
  logic [31:0] m_data = '0;
  logic [31:0] shadow [0:WORDS-1];
  bit          sh_init = 1'b0;
  int          mg;

  function automatic int exp_grant(bit ir, bit dr);
    if (ir && dr) return (FAIR && m_streak == MAXD) ? 1 : 2;
    if (ir) return 1;
    if (dr) return 2;
    return 0;
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    if (!sh_init) begin
      for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
      sh_init = 1'b1;
    end
    if (sys_rst) begin
      m_owner = 0; m_killq = 1'b0; m_streak = 0;
    end else begin
      mg = exp_grant(bus.i_req, bus.d_req);
      m_killq = bus.i_kill;
      m_owner = (mg == 1) ? 1 : (mg == 2 && !bus.d_we) ? 2 : 0;
      if (mg == 1) m_data = shadow[widx(bus.i_addr)];
      if (mg == 2) m_data = shadow[widx(bus.d_addr)];
      if (mg == 2 && bus.d_we)
        for (int b = 0; b < 4; b++)
          if (bus.d_wstrb[b]) shadow[widx(bus.d_addr)][b*8 +: 8] = bus.d_wdata[b*8 +: 8];
      if (mg == 1 || !bus.i_req) m_streak = 0;
      else if (mg == 2 && m_streak < MAXD) m_streak++;
    end
  end

  task automatic drive_idle();
    bus.i_req = 1'b0; bus.i_addr = '0; bus.i_kill = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wstrb = 4'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset();
    drive_idle();
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.ram_en, bus.i_rvalid, bus.d_rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {bus.i_gnt, bus.d_gnt, bus.ram_en, bus.i_rvalid, bus.d_rvalid});
    end
    next_cycle();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin
      failures++; $display("FAIL reset_release_rvalid got=%b exp=00", {bus.i_rvalid, bus.d_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_ifetch_only();
    for (int k = 0; k < 4; k++) begin
      bus.i_req  = (k < 3);
      bus.i_addr = 32'(k * 4);
      @(negedge sys_clk);
      if (k < 3) begin
        checks++;
        if (bus.i_gnt !== 1'b1 || bus.ram_addr !== 10'(k)) begin
          failures++; $display("FAIL ifetch_grant k=%0d gnt=%b addr=%0d exp gnt=1 addr=%0d", k, bus.i_gnt, bus.ram_addr, k);
        end
      end
      checks++;
      if (bus.i_rvalid !== (k > 0)) begin
        failures++; $display("FAIL ifetch_rvalid k=%0d got=%b exp=%b", k, bus.i_rvalid, k > 0);
      end
      if (k > 0) begin
        checks++;
        if (bus.i_rdata !== shadow[k-1]) begin
          failures++; $display("FAIL ifetch_rdata k=%0d got=%h exp=%h", k, bus.i_rdata, shadow[k-1]);
        end
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_contention();
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    @(negedge sys_clk);
    checks++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b10 || bus.ram_addr !== 10'h40) begin
      failures++; $display("FAIL contend_grant d=%b i=%b addr=%h exp d=1 i=0 addr=040", bus.d_gnt, bus.i_gnt, bus.ram_addr);
    end
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (bus.i_gnt !== 1'b1 || bus.ram_addr !== 10'h10) begin
      failures++; $display("FAIL contend_i_after gnt=%b addr=%h exp gnt=1 addr=010", bus.i_gnt, bus.ram_addr);
    end
    checks++;
    if ({bus.d_rvalid, bus.i_rvalid} !== 2'b10 || bus.d_rdata !== shadow[10'h40]) begin
      failures++; $display("FAIL contend_dload dv=%b iv=%b data=%h exp dv=1 iv=0 data=%h", bus.d_rvalid, bus.i_rvalid, bus.d_rdata, shadow[10'h40]);
    end
    next_cycle();
    drive_idle();
    @(negedge sys_clk);
    checks++;
    if ({bus.i_rvalid, bus.d_rvalid} !== 2'b10 || bus.i_rdata !== shadow[10'h10]) begin
      failures++; $display("FAIL contend_ifetch iv=%b dv=%b data=%h exp iv=1 dv=0 data=%h", bus.i_rvalid, bus.d_rvalid, bus.i_rdata, shadow[10'h10]);
    end
    next_cycle();
  endtask

  task automatic test_store();
    logic [31:0] pre, post;
    pre  = shadow[4];
    post = {pre[31:16], 16'hBEEF};
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wstrb = 4'b0011; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge sys_clk);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.ram_we !== 4'b0011 || bus.ram_addr !== 10'd4 || bus.ram_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL store_drive gnt=%b we=%b addr=%0d wd=%h exp gnt=1 we=0011 addr=4 wd=deadbeef", bus.d_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    next_cycle();
    bus.d_we = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (bus.d_rvalid !== 1'b0 || bus.ram_we !== 4'b0000) begin
      failures++; $display("FAIL store_no_return dv=%b we=%b exp dv=0 we=0000", bus.d_rvalid, bus.ram_we);
    end
    next_cycle();
    drive_idle();
    @(negedge sys_clk);
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== post) begin
      failures++; $display("FAIL store_readback dv=%b data=%h exp dv=1 data=%h", bus.d_rvalid, bus.d_rdata, post);
    end
    next_cycle();
  endtask

  task automatic test_kill();
    // {i_req, i_kill, addr, expected i_rvalid}
    logic [34:0] tbl [0:5];
    tbl[0] = {1'b1, 1'b1, 32'h20, 1'b0};
    tbl[1] = {1'b1, 1'b0, 32'h24, 1'b0};
    tbl[2] = {1'b1, 1'b0, 32'h28, 1'b1};
    tbl[3] = {1'b0, 1'b1, 32'h00, 1'b0};
    tbl[4] = {1'b0, 1'b0, 32'h00, 1'b0};
    tbl[5] = {1'b0, 1'b0, 32'h00, 1'b0};
    for (int k = 0; k < 6; k++) begin
      bus.i_req = tbl[k][34]; bus.i_kill = tbl[k][33]; bus.i_addr = tbl[k][32:1];
      @(negedge sys_clk);
      checks++;
      if (bus.i_rvalid !== tbl[k][0]) begin
        failures++; $display("FAIL kill_rvalid k=%0d got=%b exp=%b", k, bus.i_rvalid, tbl[k][0]);
      end
      if (k == 2) begin
        checks++;
        if (bus.i_rdata !== shadow[9]) begin
          failures++; $display("FAIL kill_next_data got=%h exp=%h", bus.i_rdata, shadow[9]);
        end
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_priority();
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      checks++;
      if ({bus.i_gnt, bus.d_gnt} !== (FAIR && k % 5 == 4 ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL priority_seq k=%0d got i=%b d=%b fair=%b", k, bus.i_gnt, bus.d_gnt, FAIR);
      end
      next_cycle();
    end
    bus.d_req = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (bus.i_gnt !== 1'b1) begin
      failures++; $display("FAIL priority_release got=%b exp=1", bus.i_gnt);
    end
    next_cycle();
    drive_idle();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
    repeat (4) next_cycle();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({bus.d_rvalid, bus.i_rvalid} !== 2'b00) begin
      failures++; $display("FAIL reset_mid_rvalid got=%b exp=00", {bus.d_rvalid, bus.i_rvalid});
    end
    next_cycle();
    sys_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      checks++;
      if (bus.i_gnt !== (FAIR && k == 4)) begin
        failures++; $display("FAIL reset_streak k=%0d i_gnt=%b exp=%b", k, bus.i_gnt, FAIR && k == 4);
      end
      checks++;
      if (bus.d_rvalid !== (k > 0) || (k > 0 && bus.d_rdata !== shadow[10'h20])) begin
        failures++; $display("FAIL reset_return k=%0d dv=%b data=%h exp dv=%b data=%h", k, bus.d_rvalid, bus.d_rdata, k > 0, shadow[10'h20]);
      end
      next_cycle();
    end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_random();
    bit          i_pend = 1'b0, d_pend = 1'b0;
    int          g;
    bit          exp_iv, exp_dv;
    logic [31:0] ga;
    for (int n = 0; n < 600; n++) begin
      if (!i_pend) begin
        bus.i_req = 1'($urandom_range(1)); bus.i_addr = $urandom;
      end else if ($urandom_range(9) == 0) bus.i_req = 1'b0;
      if (!d_pend) begin
        bus.d_req = 1'($urandom_range(3) != 0); bus.d_we = 1'($urandom_range(1));
        bus.d_wstrb = 4'($urandom); bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end else if ($urandom_range(9) == 0) bus.d_req = 1'b0;
      bus.i_kill = ($urandom_range(3) == 0);
      @(negedge sys_clk);
      g  = exp_grant(bus.i_req, bus.d_req);
      ga = (g == 2) ? bus.d_addr : bus.i_addr;
      checks++;
      if ({bus.i_gnt, bus.d_gnt, bus.ram_en} !== {g == 1, g == 2, g != 0}) begin
        failures++; $display("FAIL rand_grant n=%0d got=%b exp=%b", n, {bus.i_gnt, bus.d_gnt, bus.ram_en}, {g == 1, g == 2, g != 0});
      end
      if (g != 0) begin
        checks++;
        if (bus.ram_addr !== ga[11:2]) begin
          failures++; $display("FAIL rand_addr n=%0d got=%h exp=%h", n, bus.ram_addr, ga[11:2]);
        end
      end
      checks++;
      if (bus.ram_we !== ((g == 2 && bus.d_we) ? bus.d_wstrb : 4'b0000)) begin
        failures++; $display("FAIL rand_we n=%0d got=%b", n, bus.ram_we);
      end
      if (g == 2 && bus.d_we) begin
        checks++;
        if (bus.ram_wdata !== bus.d_wdata) begin
          failures++; $display("FAIL rand_wdata n=%0d got=%h exp=%h", n, bus.ram_wdata, bus.d_wdata);
        end
      end
      exp_iv = (m_owner == 1) && !m_killq && !bus.i_kill;
      exp_dv = (m_owner == 2);
      checks++;
      if ({bus.i_rvalid, bus.d_rvalid} !== {exp_iv, exp_dv}) begin
        failures++; $display("FAIL rand_rvalid n=%0d got=%b exp=%b", n, {bus.i_rvalid, bus.d_rvalid}, {exp_iv, exp_dv});
      end
      if (exp_iv || exp_dv) begin
        checks++;
        if ((exp_iv ? bus.i_rdata : bus.d_rdata) !== m_data) begin
          failures++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, exp_iv ? bus.i_rdata : bus.d_rdata, m_data);
        end
      end
      i_pend = bus.i_req && g != 1;
      d_pend = bus.d_req && g != 2;
      next_cycle();
    end
    drive_idle();
    next_cycle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_ifetch_only();
    test_contention();
    test_store();
    test_kill();
    test_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
